shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter: DEPTH, default 4, number of serial stages; legal range 2..64.
REQ-002 Ports, positional order in, clk, out, rst (one per line below); existing three-port positional hookups (in, clk, out) remain valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge only.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 in  input  1  serial data in, sampled at each rising clk.
REQ-006 out  output  1  serial data out = last stage (stage DEPTH-1), registered.
REQ-007 q  output  DEPTH  parallel view of all stages; q[0] newest bit, q[DEPTH-1] oldest, q[DEPTH-1] == out.

Function
REQ-008 Each rising clk with rst low: stage[0] <= in; stage[k] <= stage[k-1] for k = 1..DEPTH-1.
REQ-009 Latency: a bit applied at in before edge N appears on out after edge N+DEPTH-1, i.e. DEPTH rising edges from capture to out, counting the capturing edge.
REQ-010 No enable: shifting occurs on every rising clk; no combinational path from in to out or q.
REQ-011 Outputs change only immediately after a rising clk; stable between edges regardless of in activity.
REQ-012 Value on in between edges is ignored; only the value present at the rising edge is captured.
REQ-013 X/Z on in at an edge is captured and propagated as-is (no masking); reset clears it.
REQ-014 Before the first reset, stage contents are undefined; no power-up value is guaranteed.

Reset
REQ-015 rst high at a rising clk: all stages <= 0, so out = 0 and q = all zeros after that edge.
REQ-016 rst has priority over shifting: in at that edge is discarded, not captured.
REQ-017 rst held high for multiple edges: state remains all zeros.
REQ-018 Reset mid-stream: all bits in flight are lost; shifting resumes on the first edge with rst low, capturing in into stage[0].
REQ-019 rst asserted between edges has no effect until the next rising clk; purely synchronous.

Structure
REQ-020 No shared package required; DEPTH is a module parameter, with default 4 defined once in the module.
REQ-021 One sub-module, shift_register_dff: 1-bit D flip-flop with synchronous active-high reset to 0, inputs d, clk, rst, output q.
REQ-022 Top instantiates DEPTH shift_register_dff cells in a generate loop chained d(k) = q(k-1), d(0) = in.

Verification
REQ-023 Reset: rst=1 for 2 edges with in=1 -> out=0, q=4'b0000.
REQ-024 Single-bit walk (DEPTH=4): after reset, in=1 for one edge then 0 -> q = 0001, 0010, 0100, 1000, 0000 on successive edges; out = 1 only after the 4th edge.
REQ-025 Pattern stream: in = 0,1,0,0,1,1 on successive edges after reset -> out after edges 4..9 = 0,1,0,0,1,1.
REQ-026 Mid-stream reset: load q=1011, assert rst one edge with in=1 -> q=0000, out=0; next edge with in=1 -> q=0001.
REQ-027 Glitch immunity: toggle in several times between edges, stable 1 at the edge -> stage[0]=1 only; q/out unchanged between edges.
REQ-028 Parameter sweep: DEPTH=2 and DEPTH=8, single 1 injected -> out=1 exactly DEPTH edges after capture, otherwise 0.

Source files
------------

// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared constants for the serial shift register slice
//
// Purpose : holds the values every file of the shift register agrees on:
//           the legal stage-count range and the value a stage takes on reset.
// Ports   : none (package).
package shift_register_pkg;

    // Stage count range the chain is built and verified for.
    localparam int SR_DEPTH_MIN = 2;
    localparam int SR_DEPTH_MAX = 64;

    // Value every stage is forced to while rst is high.
    localparam logic SR_RESET_VALUE = 1'b0;

    // True when a requested stage count lies inside the supported range.
    function automatic bit sr_depth_legal(input int depth);
        return (depth >= SR_DEPTH_MIN) && (depth <= SR_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/shift_register_if.sv
// rtl/shift_register_if.sv - serial/parallel signal bundle for the shift register
//
// Purpose : groups the data-path signals of one shift register so a driver and
//           the chain can be hooked up as a unit.
// Ports   : sin  - serial data into stage 0
//           sout - serial data out of the last stage
//           par  - parallel view of all stages, par[0] newest
// Modports: master - drives sin, observes sout/par
//           slave  - consumes sin, produces sout/par
interface shift_register_if #(
    parameter int DEPTH = 4
);
    logic             sin;
    logic             sout;
    logic [DEPTH-1:0] par;

    modport master (
        output sin,
        input  sout,
        input  par
    );

    modport slave (
        input  sin,
        output sout,
        output par
    );

endinterface

// File: rtl/shift_register_dff.sv
// rtl/shift_register_dff.sv - one serial stage: 1-bit D flip-flop, sync reset to 0
//
// Purpose : a single storage cell of the shift chain.
// Ports   : d   - next bit for this stage
//           clk - rising-edge clock
//           rst - synchronous active-high reset, clears the stage
//           q   - stored bit
module shift_register_dff
    import shift_register_pkg::*;
(
    input  logic d,
    input  logic clk,
    input  logic rst,
    output logic q
);

    logic data_d;
    logic data_q;

    // The cell passes d straight through; unknown values are kept as-is so
    // they travel down the chain until a reset clears them.
    always_comb begin
        data_d = d;
    end

    // Reset wins over capture, so the value on d at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= SR_RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/shift_register.sv
// rtl/shift_register.sv - DEPTH-stage serial-in, serial/parallel-out shift register
//
// Purpose : shifts one bit per rising clk from in through DEPTH stages.
//           A bit captured at edge N reaches out after edge N+DEPTH-1.
// Params  : DEPTH - number of stages, supported range 2..64
// Ports   : in  - serial data in, sampled at each rising clk
//           clk - rising-edge clock, no enable
//           out - serial data out, the oldest stage (registered)
//           rst - synchronous active-high reset, clears every stage
//           q   - parallel view, q[0] newest bit, q[DEPTH-1] oldest == out
// The first three ports keep their order so older (in, clk, out) positional
// instantiations continue to connect.
module shift_register
    import shift_register_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             in,
    input  logic             clk,
    output logic             out,
    input  logic             rst,
    output logic [DEPTH-1:0] q
);

    // Stage outputs; stage_q[k] feeds stage k+1.
    logic [DEPTH-1:0] stage_q;

    // Per-stage inputs: stage 0 takes the serial input, the rest take the
    // previous stage. Built as a vector so the chain is visible in one place.
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], in};
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        shift_register_dff u_dff (
            .d   (stage_d[k]),
            .clk (clk),
            .rst (rst),
            .q   (stage_q[k])
        );
    end

    // Every output comes straight from a flop, so nothing on in can reach
    // out or q between edges.
    assign q   = stage_q;
    assign out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - self-checking bench for shift_register at DEPTH 4, 2 and 8
module tb_shift_register;
    import shift_register_pkg::*;

    logic clk;
    logic rst;
    logic din;

    int checks;
    int failures;

    // Reference: every bit captured since the last reset, newest in bit 0.
    // A DEPTH-stage register must show exactly the low DEPTH bits of this.
    logic [63:0] hist;

    shift_register_if #(.DEPTH(4)) sr4_if ();
    shift_register_if #(.DEPTH(2)) sr2_if ();
    shift_register_if #(.DEPTH(8)) sr8_if ();

    assign sr4_if.sin = din;
    assign sr2_if.sin = din;
    assign sr8_if.sin = din;

    shift_register #(.DEPTH(4)) dut4 (
        .in  (sr4_if.sin),
        .clk (clk),
        .out (sr4_if.sout),
        .rst (rst),
        .q   (sr4_if.par)
    );

    shift_register #(.DEPTH(2)) dut2 (
        .in  (sr2_if.sin),
        .clk (clk),
        .out (sr2_if.sout),
        .rst (rst),
        .q   (sr2_if.par)
    );

    shift_register #(.DEPTH(8)) dut8 (
        .in  (sr8_if.sin),
        .clk (clk),
        .out (sr8_if.sout),
        .rst (rst),
        .q   (sr8_if.par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every DUT against the reference history.
    task automatic chk_all(input string tag);
        chk({tag, "_q4"},   64'(sr4_if.par),  64'(hist[3:0]));
        chk({tag, "_out4"}, 64'(sr4_if.sout), 64'(hist[3]));
        chk({tag, "_q2"},   64'(sr2_if.par),  64'(hist[1:0]));
        chk({tag, "_out2"}, 64'(sr2_if.sout), 64'(hist[1]));
        chk({tag, "_q8"},   64'(sr8_if.par),  64'(hist[7:0]));
        chk({tag, "_out8"}, 64'(sr8_if.sout), 64'(hist[7]));
    endtask

    // Called just after a negedge: drive, take one rising edge, update the
    // reference, check after the outputs settle, then return at the next negedge.
    task automatic step(input logic i, input logic r, input string tag);
        din = i;
        rst = r;
        @(posedge clk);
        if (r) hist = '0;
        else   hist = {hist[62:0], i};
        #1;
        chk_all(tag);
        @(negedge clk);
    endtask

    initial begin
        int first2;
        int first8;
        logic [3:0] walk_exp [5];
        logic       stream [6];

        checks   = 0;
        failures = 0;
        hist     = '0;
        din      = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        // Reset held for two edges with in=1: everything zero.
        step(1'b1, 1'b1, "rst1");
        step(1'b1, 1'b1, "rst2");
        chk("rst_q4_const", 64'(sr4_if.par), 64'h0);
        chk("rst_out4_const", 64'(sr4_if.sout), 64'h0);

        // Single 1 walking through the 4-stage register.
        walk_exp[0] = 4'b0001;
        walk_exp[1] = 4'b0010;
        walk_exp[2] = 4'b0100;
        walk_exp[3] = 4'b1000;
        walk_exp[4] = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            step((n == 0) ? 1'b1 : 1'b0, 1'b0, "walk");
            chk($sformatf("walk_q4_e%0d", n + 1), 64'(sr4_if.par), 64'(walk_exp[n]));
            chk($sformatf("walk_out4_e%0d", n + 1), 64'(sr4_if.sout), (n == 3) ? 64'h1 : 64'h0);
        end

        // Pattern stream: in at edges 1..6 reappears on out after edges 4..9.
        step(1'b0, 1'b1, "pat_rst");
        stream[0] = 1'b0; stream[1] = 1'b1; stream[2] = 1'b0;
        stream[3] = 1'b0; stream[4] = 1'b1; stream[5] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step((e <= 6) ? stream[e-1] : 1'b0, 1'b0, "pat");
            if (e >= 4)
                chk($sformatf("pat_out4_e%0d", e), 64'(sr4_if.sout), 64'(stream[e-4]));
        end

        // Mid-stream reset: load 1011, reset with in=1, then resume.
        step(1'b1, 1'b0, "load");
        step(1'b0, 1'b0, "load");
        step(1'b1, 1'b0, "load");
        step(1'b1, 1'b0, "load");
        chk("mid_loaded_q4", 64'(sr4_if.par), 64'hb);
        step(1'b1, 1'b1, "mid_rst");
        chk("mid_rst_q4", 64'(sr4_if.par), 64'h0);
        chk("mid_rst_out4", 64'(sr4_if.sout), 64'h0);
        step(1'b1, 1'b0, "mid_resume");
        chk("mid_resume_q4", 64'(sr4_if.par), 64'h1);

        // Glitches between edges: outputs hold, only the edge value is taken.
        step(1'b0, 1'b1, "gl_rst");
        step(1'b1, 1'b0, "gl_pre");
        step(1'b0, 1'b0, "gl_pre");
        for (int g = 0; g < 4; g++) begin
            din = ~din;
            #1;
            chk($sformatf("glitch_hold_%0d", g), 64'(sr4_if.par), 64'(hist[3:0]));
            rst = (g == 1);
            #0;
            rst = 1'b0;
        end
        step(1'b1, 1'b0, "glitch_edge");
        chk("glitch_q4", 64'(sr4_if.par), 64'b0101);

        // Depth sweep: one injected 1, find the edge where out first rises.
        step(1'b0, 1'b1, "sw_rst");
        first2 = -1;
        first8 = -1;
        for (int e = 1; e <= 10; e++) begin
            step((e == 1) ? 1'b1 : 1'b0, 1'b0, "sweep");
            if (sr2_if.sout === 1'b1 && first2 < 0) first2 = e;
            if (sr8_if.sout === 1'b1 && first8 < 0) first8 = e;
        end
        chk("sweep_d2_edge", 64'(first2), 64'd2);
        chk("sweep_d8_edge", 64'(first8), 64'd8);

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
